px_diff_pipe: RTL
=================

Name: px_diff_pipe

Overview:
- Streaming, pipelined successor to the combinational per-pixel colour distance used in the image-processing path.
- Takes pixel pairs (current/reference frame) on a valid/ready stream. Emits a per-pixel distance plus a threshold "hit" flag.
- Per-channel widths are parametrised; the distance mode (L1 or sum of squares) is runtime-selectable.
- Accumulates the hit count per frame and reports it at frame end, for motion detection ahead of the control logic.

Parameters:
- R_W, 3, red channel width (MSBs of pixel)
- G_W, 3, green channel width (middle bits)
- B_W, 2, blue channel width (LSBs)
- CNT_W, 20, width of per-frame hit counter
- Derived localparam PX_W = R_W+G_W+B_W.
- Derived localparam DIFF_W = 2*max(R_W,G_W,B_W)+2 (default 8). This covers the worst-case squared sum.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mode  in  1  0 = L1 (sum of abs diffs), 1 = L2sq (sum of squared abs diffs)
- thresh  in  DIFF_W  hit threshold
- s_valid  in  1  input pixel pair valid
- s_ready  out  1  block accepts input
- s_px1  in  PX_W  pixel A, packed {r,g,b}
- s_px2  in  PX_W  pixel B, packed {r,g,b}
- s_last  in  1  last pixel of frame
- m_valid  out  1  result valid
- m_ready  in  1  downstream accepts result
- m_diff  out  DIFF_W  distance, zero-extended
- m_hit  out  1  m_diff > thresh
- m_last  out  1  last flag, delayed with its pixel
- frame_cnt  out  CNT_W  hits in the most recently completed frame
- frame_cnt_valid  out  1  one-cycle pulse when frame_cnt updates

Behaviour:
- Reset: one clock clk; rst is asynchronous, active-high. On reset, all outputs and internal state clear to 0: m_valid, m_diff, m_hit, m_last, frame_cnt, frame_cnt_valid, the hit accumulator, and stage-1 valid. s_ready reads 1 from the first cycle after reset release.
- Handshake: a transfer occurs on a cycle where valid & ready. Once m_valid rises, m_diff/m_hit/m_last stay stable until m_ready.
- Pipeline and stall: two register stages that stall together.
  - en = m_ready | ~m_valid, and s_ready = en.
  - Bubbles propagate normally; stage-1 valid advances on en.
- Latency: 2 cycles from input handshake to m_valid with no stall. Throughput is 1 pixel/clk when m_ready is held high.
- Stage 1 (captured when en):
  - Per-channel absolute differences: |r1-r2| at R_W bits, |g1-g2| at G_W bits, |b1-b2| at B_W bits.
  - mode, thresh and s_last are captured alongside, so a mode/thresh change applies only to pixels accepted afterwards.
- Stage 2 (captured when en):
  - L1 result: zero-extend each diff to DIFF_W and sum.
  - L2sq result: square each diff at full width (2*width bits), zero-extend and sum.
  - The sum never overflows DIFF_W.
  - m_hit = (result > captured thresh), strict compare. thresh = 0 gives a hit on any nonzero diff.
- Frame accumulator:
  - Updates only on an output handshake.
  - If m_hit, acc increments, saturating at 2^CNT_W-1 (no wrap).
  - If m_last on the same handshake: frame_cnt gets the updated acc (this beat's hit included), acc clears to 0, and frame_cnt_valid = 1 for one cycle.
  - Otherwise frame_cnt_valid = 0 and frame_cnt holds its value.
- Boundary cases:
  - Back-to-back last beats: each pixel is a 1-pixel frame, and a pulse fires every handshake.
  - Stall on a last beat: no pulse until the handshake completes.
  - Reset mid-frame: in-flight pixels and the partial count are discarded; no frame_cnt_valid pulse.

Decomposition:
- Package px_pkg:
  - mode encoding constants MODE_L1 = 0, MODE_L2SQ = 1
  - max() function for DIFF_W
  - default channel widths
- Sub-module px_chan_absdiff (parameter W): combinational |a-b| and its square. Instantiated once per channel in stage 1/2.
- Remainder of the block: pipeline registers, handshake logic, accumulator.

Test Plan:
- L1 and L2sq, defaults (R_W=3, G_W=3, B_W=2):
  - s_px1=8'hE3 (r7,g0,b3), s_px2=8'h00, mode=0, thresh=9 -> m_diff=10, m_hit=1, 2 cycles after accept.
  - Same pair with mode=1 -> m_diff=58.
- Symmetry and threshold edge:
  - s_px1=8'h24, s_px2=8'h48 -> L1=2 and L2sq=2. Swapping pixels gives the same values.
  - thresh=2 -> m_hit=0; thresh=1 -> m_hit=1.
- Backpressure:
  - Stream 6 pairs with m_ready toggling 1,0,0,1,... -> outputs arrive in order with none lost or duplicated.
  - Outputs stay stable while m_ready=0. s_ready=0 exactly when m_valid & ~m_ready.
- Frame count:
  - 8-pixel frame with 3 hits, last on pixel 8 -> single frame_cnt_valid pulse with frame_cnt=3.
  - The next frame has 0 hits -> frame_cnt=0.
  - A hit on the last pixel itself is counted.
- Saturation:
  - CNT_W=2, 5 hits in one frame -> frame_cnt=3.
- Reset mid-operation:
  - Assert rst with 2 pixels in flight and acc=4 -> all outputs 0 immediately (asynchronous).
  - After release, a fresh 1-pixel hit frame gives frame_cnt=1.

Source files
------------

// File: rtl/px_pkg.sv
// Shared constants and helpers for the pixel difference pipeline.
package px_pkg;

  // Distance mode encoding on the mode input.
  localparam logic MODE_L1   = 1'b0;
  localparam logic MODE_L2SQ = 1'b1;

  // Default channel layout of an 8-bit {r,g,b} pixel and the frame counter width.
  localparam int DEF_R_W   = 3;
  localparam int DEF_G_W   = 3;
  localparam int DEF_B_W   = 2;
  localparam int DEF_CNT_W = 20;

  // Widest of the three channels; sizes the distance so the squared sum fits.
  function automatic int px_max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/px_chan_absdiff.sv
// One colour channel: absolute difference of two samples and its square.
module px_chan_absdiff #(
  parameter int W = 3
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [W-1:0]   absd,
  output logic [2*W-1:0] sq
);

  logic [2*W-1:0] absd_ext;

  // Magnitude of the difference, then squared at full 2*W width.
  always_comb begin
    absd     = (a >= b) ? (a - b) : (b - a);
    absd_ext = {{W{1'b0}}, absd};
    sq       = absd_ext * absd_ext;
  end

endmodule

// File: rtl/px_diff_pipe.sv
// Two-stage streaming colour distance (L1 or sum of squares) with a
// threshold hit flag and a per-frame hit counter reported at frame end.
//
// Handshake: a beat transfers on any rising edge where valid & ready are both
// high. m_valid never drops and m_diff/m_hit/m_last never change while
// m_valid & ~m_ready. Both stages advance together on en = m_ready | ~m_valid,
// and s_ready is exactly en.
module px_diff_pipe
  import px_pkg::*;
#(
  parameter int R_W   = DEF_R_W,
  parameter int G_W   = DEF_G_W,
  parameter int B_W   = DEF_B_W,
  parameter int CNT_W = DEF_CNT_W,
  localparam int PX_W   = R_W + G_W + B_W,
  localparam int DIFF_W = 2 * px_max3(R_W, G_W, B_W) + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [DIFF_W-1:0] thresh,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [PX_W-1:0]   s_px1,
  input  logic [PX_W-1:0]   s_px2,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DIFF_W-1:0] m_diff,
  output logic              m_hit,
  output logic              m_last,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              frame_cnt_valid
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic en;
  logic out_hs;

  // Per-channel combinational differences of the incoming pair.
  logic [R_W-1:0]   dr;
  logic [G_W-1:0]   dg;
  logic [B_W-1:0]   db;
  logic [2*R_W-1:0] sr;
  logic [2*G_W-1:0] sg;
  logic [2*B_W-1:0] sb;

  // Stage 1 registers.
  logic              s1_valid;
  logic [R_W-1:0]    s1_dr;
  logic [G_W-1:0]    s1_dg;
  logic [B_W-1:0]    s1_db;
  logic [2*R_W-1:0]  s1_sr;
  logic [2*G_W-1:0]  s1_sg;
  logic [2*B_W-1:0]  s1_sb;
  logic              s1_mode;
  logic [DIFF_W-1:0] s1_thresh;
  logic              s1_last;

  // Stage 2 combinational sums.
  logic [DIFF_W-1:0] l1_sum;
  logic [DIFF_W-1:0] l2_sum;
  logic [DIFF_W-1:0] result;

  // Frame accumulator.
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] acc_next;

  assign en      = m_ready | ~m_valid;
  assign s_ready = en;
  assign out_hs  = m_valid & m_ready;

  px_chan_absdiff #(.W(R_W)) u_r (
    .a    (s_px1[PX_W-1 -: R_W]),
    .b    (s_px2[PX_W-1 -: R_W]),
    .absd (dr),
    .sq   (sr)
  );

  px_chan_absdiff #(.W(G_W)) u_g (
    .a    (s_px1[B_W +: G_W]),
    .b    (s_px2[B_W +: G_W]),
    .absd (dg),
    .sq   (sg)
  );

  px_chan_absdiff #(.W(B_W)) u_b (
    .a    (s_px1[0 +: B_W]),
    .b    (s_px2[0 +: B_W]),
    .absd (db),
    .sq   (sb)
  );

  // Stage 1: capture channel differences with the mode/threshold/last in force
  // at acceptance, so later control changes only affect later pixels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_dr     <= '0;
      s1_dg     <= '0;
      s1_db     <= '0;
      s1_sr     <= '0;
      s1_sg     <= '0;
      s1_sb     <= '0;
      s1_mode   <= MODE_L1;
      s1_thresh <= '0;
      s1_last   <= 1'b0;
    end else if (en) begin
      s1_valid  <= s_valid;
      s1_dr     <= dr;
      s1_dg     <= dg;
      s1_db     <= db;
      s1_sr     <= sr;
      s1_sg     <= sg;
      s1_sb     <= sb;
      s1_mode   <= mode;
      s1_thresh <= thresh;
      s1_last   <= s_last;
    end
  end

  // Stage 2 arithmetic: both sums fit in DIFF_W by construction.
  always_comb begin
    l1_sum = DIFF_W'(s1_dr) + DIFF_W'(s1_dg) + DIFF_W'(s1_db);
    l2_sum = DIFF_W'(s1_sr) + DIFF_W'(s1_sg) + DIFF_W'(s1_sb);
    result = (s1_mode == MODE_L2SQ) ? l2_sum : l1_sum;
  end

  // Stage 2 / output register: holds steady while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_diff  <= '0;
      m_hit   <= 1'b0;
      m_last  <= 1'b0;
    end else if (en) begin
      m_valid <= s1_valid;
      m_diff  <= result;
      m_hit   <= (result > s1_thresh);
      m_last  <= s1_last;
    end
  end

  // Saturating increment of the running hit count for the beat leaving now.
  always_comb begin
    acc_next = acc;
    if (m_hit && (acc != CNT_MAX)) acc_next = acc + 1'b1;
  end

  // Frame accumulator: counts on output handshakes, publishes and clears on last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc             <= '0;
      frame_cnt       <= '0;
      frame_cnt_valid <= 1'b0;
    end else begin
      frame_cnt_valid <= 1'b0;
      if (out_hs) begin
        if (m_last) begin
          frame_cnt       <= acc_next;
          acc             <= '0;
          frame_cnt_valid <= 1'b1;
        end else begin
          acc <= acc_next;
        end
      end
    end
  end

endmodule
